// File: rtl/parity_pkg.sv
// Shared types and helpers for the chunked parity accumulator.
// Holds the FSM state encoding and the words-to-chunks ceiling division.
package parity_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int nchunk(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/parity_chunk_xor.sv
// Reduction XOR of one CHUNK-bit slice; the accumulator folds one slice per cycle.
module parity_chunk_xor #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] chunk_i,
  output logic             par_o
);

  assign par_o = ^chunk_i;

endmodule

// File: rtl/parity_accum.sv
// Multi-cycle parity generator/checker folding CHUNK bits of a WIDTH-bit word per cycle.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// the producer holds its payload while valid is high, ready never depends on valid.
module parity_accum
  import parity_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_odd,
  input  logic             in_chk,
  input  logic             in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_par,
  output logic             out_err,
  output state_e           dbg_state
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  // Shift register is widened to a whole number of chunks so the last chunk is zero-padded.
  localparam int SW     = NCHUNK * CHUNK;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_e          state_q, state_d;
  logic [SW-1:0]   sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            acc_q, acc_d;
  logic            odd_q, odd_d;
  logic            chk_q, chk_d;
  logic            par_q, par_d;
  logic            out_par_q, out_par_d;
  logic            out_err_q, out_err_d;
  logic            chunk_par;

  parity_chunk_xor #(
    .CHUNK (CHUNK)
  ) u_chunk_xor (
    .chunk_i (sr_q[CHUNK-1:0]),
    .par_o   (chunk_par)
  );

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    odd_d     = odd_q;
    chk_d     = chk_q;
    par_d     = par_q;
    out_par_d = out_par_q;
    out_err_d = out_err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sr_d    = SW'(in_data);
          odd_d   = in_odd;
          chk_d   = in_chk;
          par_d   = in_par;
          acc_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_d = acc_q ^ chunk_par;
        sr_d  = sr_q >> CHUNK;
        if (cnt_q == LAST) begin
          // Result is registered on the way into DONE so it is stable for the whole wait.
          out_par_d = acc_d ^ odd_q;
          out_err_d = chk_q & (out_par_d != par_q);
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= 1'b0;
      odd_q     <= 1'b0;
      chk_q     <= 1'b0;
      par_q     <= 1'b0;
      out_par_q <= 1'b0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      odd_q     <= odd_d;
      chk_q     <= chk_d;
      par_q     <= par_d;
      out_par_q <= out_par_d;
      out_err_q <= out_err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_par   = out_par_q;
  assign out_err   = out_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_parity_accum.sv
// Directed bench for parity_accum in three geometries: 7/2, 7/7 (single chunk), 16/3 (padded).
module tb_parity_accum;
  import parity_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared stimulus, per-DUT valid ----------------
  logic [15:0] din = '0;
  logic        odd = 1'b0, chk = 1'b0, par = 1'b0;
  logic        oready = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0, c_valid = 1'b0;

  logic   a_ready, a_ovalid, a_par, a_err;
  logic   b_ready, b_ovalid, b_par, b_err;
  logic   c_ready, c_ovalid, c_par, c_err;
  state_e a_st, b_st, c_st;

  parity_accum #(.WIDTH(7), .CHUNK(2)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_data(din[6:0]),
    .in_odd(odd), .in_chk(chk), .in_par(par), .out_valid(a_ovalid), .out_ready(oready),
    .out_par(a_par), .out_err(a_err), .dbg_state(a_st));

  parity_accum #(.WIDTH(7), .CHUNK(7)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_data(din[6:0]),
    .in_odd(odd), .in_chk(chk), .in_par(par), .out_valid(b_ovalid), .out_ready(oready),
    .out_par(b_par), .out_err(b_err), .dbg_state(b_st));

  parity_accum #(.WIDTH(16), .CHUNK(3)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_ready), .in_data(din),
    .in_odd(odd), .in_chk(chk), .in_par(par), .out_valid(c_ovalid), .out_ready(oready),
    .out_par(c_par), .out_err(c_err), .dbg_state(c_st));

  // Selected-DUT view used by the driver task.
  int     sel = 0;
  logic   cur_ready, cur_ovalid, cur_par, cur_err;
  state_e cur_st;
  always_comb begin
    cur_ready = a_ready; cur_ovalid = a_ovalid; cur_par = a_par; cur_err = a_err; cur_st = a_st;
    case (sel)
      1: begin cur_ready = b_ready; cur_ovalid = b_ovalid; cur_par = b_par; cur_err = b_err; cur_st = b_st; end
      2: begin cur_ready = c_ready; cur_ovalid = c_ovalid; cur_par = c_par; cur_err = c_err; cur_st = c_st; end
      default: ;
    endcase
  end

  // ---------------- scoreboard ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input int s, input logic v);
    case (s)
      0: a_valid = v;
      1: b_valid = v;
      default: c_valid = v;
    endcase
  endtask

  // Sends one word; optionally scrambles inputs while busy and stalls out_ready in DONE.
  task automatic run_word(input int s, input logic [15:0] data, input logic odd_v,
                          input logic chk_v, input logic par_v, input int exp_lat,
                          input logic exp_p, input logic exp_e, input bit junk,
                          input int stall, input string tag, input bit full);
    int  lat;
    logic hold_p, hold_e;
    sel = s;
    din = data; odd = odd_v; chk = chk_v; par = par_v;
    oready = (stall == 0);
    #0;
    if (full) check({tag, " ready_before"}, 32'(cur_ready), 32'd1);
    set_valid(s, 1'b1);
    tick();
    lat = 1;
    if (full) check({tag, " state_busy"}, 32'(cur_st), 32'(ST_BUSY));
    if (junk) begin
      din = ~data; odd = ~odd_v; chk = ~chk_v; par = ~par_v;
    end else begin
      set_valid(s, 1'b0);
    end
    while (!cur_ovalid && lat < 40) begin
      tick();
      lat++;
    end
    set_valid(s, 1'b0);
    if (full) check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " out_par"}, 32'(cur_par), 32'(exp_p));
    check({tag, " out_err"}, 32'(cur_err), 32'(exp_e));
    hold_p = cur_par;
    hold_e = cur_err;
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, " stall_valid"}, 32'(cur_ovalid), 32'd1);
      check({tag, " stall_par"},   32'(cur_par),    32'(hold_p));
      check({tag, " stall_err"},   32'(cur_err),    32'(hold_e));
      check({tag, " stall_ready"}, 32'(cur_ready),  32'd0);
    end
    oready = 1'b1;
    tick();
    if (full) begin
      check({tag, " back_idle"},  32'(cur_ready),  32'd1);
      check({tag, " valid_drop"}, 32'(cur_ovalid), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0] e;
    logic       o, p, c;
    repeat (2) tick();
    rst = 1'b0;
    check("rst a_ready",  32'(a_ready),  32'd1);
    check("rst a_ovalid", 32'(a_ovalid), 32'd0);
    check("rst a_par",    32'(a_par),    32'd0);
    check("rst a_err",    32'(a_err),    32'd0);
    check("rst a_state",  32'(a_st),     32'(ST_IDLE));
    check("rst b_ready",  32'(b_ready),  32'd1);
    check("rst c_ovalid", 32'(c_ovalid), 32'd0);

    // 1011001 has four ones: even parity 0, odd parity 1.
    run_word(0, 16'h0059, 1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b0, 0, 0, "gen_even", 1);
    run_word(0, 16'h0059, 1'b1, 1'b0, 1'b0, 5, 1'b1, 1'b0, 0, 0, "gen_odd", 1);
    run_word(0, 16'h0059, 1'b0, 1'b1, 1'b1, 5, 1'b0, 1'b1, 0, 0, "chk_bad", 1);
    run_word(0, 16'h0059, 1'b0, 1'b1, 1'b0, 5, 1'b0, 1'b0, 0, 0, "chk_good", 1);
    // Inputs flipped and in_valid kept high while busy must not disturb the word.
    run_word(0, 16'h0007, 1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b0, 1, 0, "ignore_busy", 1);
    // Check-mode mismatch held through a 6-cycle out_ready stall.
    run_word(0, 16'h0059, 1'b1, 1'b1, 1'b0, 5, 1'b1, 1'b1, 0, 6, "stall", 1);

    // Reset on the second BUSY cycle discards the word.
    sel = 0;
    din = 16'h0059; odd = 1'b1; chk = 1'b1; par = 1'b0;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst ready", 32'(a_ready),  32'd1);
    check("midrst valid", 32'(a_ovalid), 32'd0);
    check("midrst par",   32'(a_par),    32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (a_ovalid) seen = 1;
      end
      check("midrst no_output", 32'(seen), 32'd0);
    end
    run_word(0, 16'h0001, 1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b0, 0, 0, "after_rst", 1);

    // Single-chunk geometry: latency 2, then every word in both modes.
    run_word(1, 16'h0059, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 0, 0, "b_lat", 1);
    for (int m = 0; m < 2; m++) begin
      for (int w = 0; w < 128; w++) begin
        logic [6:0] d;
        d = 7'(w);
        o = d[1];
        c = m[0];
        p = d[0];
        e[0] = (^d) ^ o;
        e[1] = c & (e[0] != p);
        exp_q.push_back(e);
        e = exp_q.pop_front();
        run_word(1, {9'd0, d}, o, c, p, 2, e[0], e[1], 0, 0, "b_sweep", (w % 32) == 0);
      end
    end

    // 16-bit word in 3-bit chunks: last chunk is a single bit plus padding.
    run_word(2, 16'hFFFF, 1'b0, 1'b0, 1'b0, 7, 1'b0, 1'b0, 0, 0, "c_ffff", 1);
    run_word(2, 16'h8000, 1'b0, 1'b0, 1'b0, 7, 1'b1, 1'b0, 0, 0, "c_8000", 1);
    run_word(2, 16'h8001, 1'b1, 1'b1, 1'b0, 7, 1'b1, 1'b1, 0, 0, "c_chk", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/parity_accum.md
PARITY_ACCUM -- requirements
Module: parity_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 7, data word width in bits (WIDTH >= 1).
REQ-002 SHALL have parameter CHUNK, default 2, bits folded per cycle (1 <= CHUNK <= WIDTH).
REQ-003 SHALL derive localparam NCHUNK = ceil(WIDTH/CHUNK), cycles per word.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, request carries a word.
REQ-007 SHALL have port in_ready, output, 1, block accepts a word.
REQ-008 SHALL have port in_data, input, WIDTH, word to process.
REQ-009 SHALL have port in_odd, input, 1, 1 = odd parity, 0 = even parity.
REQ-010 SHALL have port in_chk, input, 1, 1 = check mode, 0 = generate mode.
REQ-011 SHALL have port in_par, input, 1, expected parity bit (check mode only).
REQ-012 SHALL have port out_valid, output, 1, result available.
REQ-013 SHALL have port out_ready, input, 1, consumer takes result.
REQ-014 SHALL have port out_par, output, 1, generated parity bit.
REQ-015 SHALL have port out_err, output, 1, check-mode mismatch flag.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-018 SHALL, in IDLE on in_valid & in_ready, capture in_data, in_odd, in_chk, in_par, clear accumulator and chunk counter, enter BUSY.
REQ-019 SHALL, each BUSY cycle, XOR the reduction-XOR of the low CHUNK bits of the shift register into the accumulator, shift right by CHUNK with zero fill, increment counter.
REQ-020 SHALL zero-pad the final chunk when CHUNK does not divide WIDTH.
REQ-021 SHALL leave BUSY for DONE on the cycle the counter equals NCHUNK-1; exactly NCHUNK BUSY cycles per word.
REQ-022 SHALL assert out_valid on the cycle after the last BUSY cycle: handshake-to-out_valid latency NCHUNK+1 cycles.
REQ-023 SHALL register out_par = accumulator XOR captured in_odd.
REQ-024 SHALL register out_err = captured in_chk AND (out_par != captured in_par); out_err = 0 in generate mode.
REQ-025 SHALL hold out_valid, out_par, out_err stable in DONE until out_ready = 1, then return to IDLE next cycle.
REQ-026 SHALL ignore in_valid and all in_* inputs outside IDLE; no back-to-back acceptance (one bubble cycle in IDLE per word).
REQ-027 SHALL, when NCHUNK = 1, spend one BUSY cycle (latency 2).
REQ-028 SHALL size the chunk counter as max(1, clog2(NCHUNK)) bits; no wrap beyond NCHUNK-1.

Reset
REQ-029 SHALL, on rst = 1 at a rising edge, enter IDLE, clear accumulator, counter, shift register, out_par, out_err; out_valid = 0, in_ready = 1 on following cycle.
REQ-030 SHALL let rst override any concurrent handshake; a word in BUSY or DONE at reset is discarded with no output.

Structure
REQ-031 SHALL place the state enum (IDLE, BUSY, DONE) and an nchunk(WIDTH, CHUNK) ceil-division function in shared package parity_pkg.
REQ-032 SHALL implement the per-chunk reduction XOR in sub-module parity_chunk_xor (parameter CHUNK, input CHUNK bits, output 1 bit), instantiated once.

Verification
REQ-033 SHALL cover: WIDTH=7, CHUNK=2, in_data=7'b1011001, in_odd=0, in_chk=0 -> out_valid 5 cycles after handshake, out_par=0, out_err=0; same with in_odd=1 -> out_par=1.
REQ-034 SHALL cover: check mode, in_data=7'b1011001, in_odd=0, in_par=1 -> out_par=0, out_err=1; in_par=0 -> out_err=0.
REQ-035 SHALL cover: out_ready held 0 for 6 cycles in DONE -> out_valid, out_par, out_err constant, in_ready=0; accept on out_ready=1, IDLE next cycle.
REQ-036 SHALL cover: rst pulsed on second BUSY cycle -> no out_valid, in_ready=1 next cycle; next word 7'b0000001 even -> out_par=1.
REQ-037 SHALL cover: WIDTH=7, CHUNK=7 -> latency 2; all 128 words, both modes -> out_par equals reduction-XOR(in_data) XOR in_odd.
REQ-038 SHALL cover: WIDTH=16, CHUNK=3 (padded last chunk) -> 0xFFFF even gives out_par=0, 0x8000 gives out_par=1, latency 7.
